// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl_pkg
// Purpose  : Shared op-bit indices, FSM encodings and op decode for div_ctrl.
// Revision : 1.0
// ============================================================================
package div_ctrl_pkg;

    localparam int DIV_OP_DIV_W  = 0;
    localparam int DIV_OP_DIV_WU = 1;
    localparam int DIV_OP_MOD_W  = 2;
    localparam int DIV_OP_MOD_WU = 3;

    localparam int DIV_LATENCY   = 33;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Anything that is not a clean one-hot code degrades to mod.wu.
    function automatic logic [3:0] decode_op(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0100: return op;
            default:                   return 4'b1000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring radix-2 division iteration.
// Revision : 1.0
// ============================================================================
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    logic [DATA_W:0] w_shifted;
    logic [DATA_W:0] w_diff;

    // rem_in < divisor, so the shifted value fits in DATA_W+1 bits and the
    // top bit of the difference is a true sign bit.
    assign w_shifted = {rem_in, dividend_bit};
    assign w_diff    = w_shifted - {1'b0, divisor};
    assign q_bit     = ~w_diff[DATA_W];
    assign rem_out   = q_bit ? w_diff[DATA_W-1:0] : w_shifted[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Multi-cycle signed/unsigned divide/modulo controller for EX.
// Revision : 1.0
// ============================================================================
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        div_op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_quot_sel;
    logic              r_q_sign;
    logic              r_r_sign;
    logic [DATA_W-1:0] r_dq;
    logic [DATA_W-1:0] r_divisor;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_result;

    logic [3:0]        w_op_dec;
    logic              w_signed;
    logic [DATA_W-1:0] w_abs1;
    logic [DATA_W-1:0] w_abs2;
    logic              w_accept;
    logic              w_last;
    logic              w_q_bit;
    logic [DATA_W-1:0] w_rem_next;
    logic [DATA_W-1:0] w_q_next;
    logic [DATA_W-1:0] w_q_fix;
    logic [DATA_W-1:0] w_r_fix;

    assign w_op_dec = decode_op(div_op);
    assign w_signed = w_op_dec[DIV_OP_DIV_W] | w_op_dec[DIV_OP_MOD_W];
    assign w_abs1   = (w_signed && src1[DATA_W-1]) ? -src1 : src1;
    assign w_abs2   = (w_signed && src2[DATA_W-1]) ? -src2 : src2;
    assign w_accept = in_valid & in_ready & ~flush;
    assign w_last   = (r_cnt == '0);

    div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem_in       (r_rem),
        .dividend_bit (r_dq[DATA_W-1]),
        .divisor      (r_divisor),
        .rem_out      (w_rem_next),
        .q_bit        (w_q_bit)
    );

    // r_dq starts as |dividend| and fills with quotient bits from the LSB.
    assign w_q_next = {r_dq[DATA_W-2:0], w_q_bit};
    assign w_q_fix  = r_q_sign ? -w_q_next : w_q_next;
    assign w_r_fix  = r_r_sign ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_state_next = S_CALC;
                S_CALC:  if (w_last) w_state_next = S_DONE;
                S_DONE:  if (out_ready) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_quot_sel <= 1'b0;
            r_q_sign   <= 1'b0;
            r_r_sign   <= 1'b0;
            r_dq       <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_result   <= '0;
        end else if (w_accept) begin
            r_cnt      <= CNT_W'(DATA_W - 1);
            r_quot_sel <= w_op_dec[DIV_OP_DIV_W] | w_op_dec[DIV_OP_DIV_WU];
            r_q_sign   <= w_signed & (src1[DATA_W-1] ^ src2[DATA_W-1]);
            r_r_sign   <= w_signed & src1[DATA_W-1];
            r_dq       <= w_abs1;
            r_divisor  <= w_abs2;
            r_rem      <= '0;
        end else if (r_state == S_CALC && !flush) begin
            r_dq  <= w_q_next;
            r_rem <= w_rem_next;
            r_cnt <= w_last ? r_cnt : r_cnt - 1'b1;
            // The final step registers the sign-corrected result straight into DONE.
            if (w_last) begin
                r_result <= r_quot_sel ? w_q_fix : w_r_fix;
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Purpose  : Self-checking scoreboard bench for div_ctrl.
// Revision : 1.0
// ============================================================================
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   div_op = 4'd0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         busy;

    int n_pass = 0;
    int n_total = 0;
    logic [W-1:0] exp_q[$];

    div_ctrl #(.DATA_W(W), .CNT_W(6)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div_op    (div_op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [3:0]   d;
        logic         sg;
        logic [W-1:0] ma, mb, uq, ur;
        d  = (op == 4'b0001 || op == 4'b0010 || op == 4'b0100) ? op : 4'b1000;
        sg = d[0] | d[2];
        ma = (sg && a[W-1]) ? -a : a;
        mb = (sg && b[W-1]) ? -b : b;
        if (mb == '0) begin
            uq = '1;
            ur = ma;
        end else begin
            uq = ma / mb;
            ur = ma % mb;
        end
        if (sg && (a[W-1] ^ b[W-1])) uq = -uq;
        if (sg && a[W-1]) ur = -ur;
        return (d[0] | d[1]) ? uq : ur;
    endfunction

    // Drives one request at a negedge; returns one cycle after the accept edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
        int waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_total++;
        if (!in_ready) $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        else n_pass++;
        in_valid = 1'b1;
        div_op   = op;
        src1     = a;
        src2     = b;
        exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        div_op   = 4'($urandom);
        src1     = $urandom;
        src2     = $urandom;
    endtask

    task automatic wait_out(output logic [W-1:0] res, output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        res = result;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_hs: in_ready=%b busy=%b required 1 0", in_ready, busy);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b0 || result !== '0)
            $display("FAIL reset_out: out_valid=%b result=%h required 0 0", out_valid, result);
        else n_pass++;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [W-1:0] res, exp;
        int cyc;
        send(4'b0010, 32'd100, 32'd7, 32'd14);
        n_total++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL lat_busy: in_ready=%b busy=%b required 0 1", in_ready, busy);
        else n_pass++;
        wait_out(res, cyc);
        exp = exp_q.pop_front();
        n_total++;
        if (cyc != DIV_LATENCY)
            $display("FAIL lat_cycles: got %0d required %0d", cyc, DIV_LATENCY);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b1 || res !== exp)
            $display("FAIL lat_result: valid=%b result=%h required %h", out_valid, res, exp);
        else n_pass++;
        ack();
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL lat_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_signed_edges();
        logic [3:0]   ops[6] = '{4'b0100, 4'b0001, 4'b0001, 4'b0100, 4'b0010, 4'b1000};
        logic [W-1:0] as[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000,
                                 32'd5, 32'd5};
        logic [W-1:0] bs[6]  = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [W-1:0] es[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0,
                                 32'hFFFF_FFFF, 32'd5};
        logic [W-1:0] res, exp;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            send(ops[i], as[i], bs[i], es[i]);
            wait_out(res, cyc);
            exp = exp_q.pop_front();
            n_total++;
            if (out_valid !== 1'b1 || res !== exp)
                $display("FAIL edge_case%0d: valid=%b result=%h required %h", i, out_valid, res, exp);
            else n_pass++;
            ack();
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        send(4'b0001, 32'd1000, 32'd3, 32'd333);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        void'(exp_q.pop_back());
        n_total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL flush_idle: in_ready=%b busy=%b out_valid=%b required 1 0 0",
                     in_ready, busy, out_valid);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL flush_no_result: out_valid cycles=%0d required 0", seen);
        else n_pass++;
        in_valid = 1'b1;
        flush    = 1'b1;
        div_op   = 4'b0010;
        src1     = 32'd50;
        src2     = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        n_total++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL flush_same_cycle: in_ready=%b busy=%b required 1 0", in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_hold();
        logic [W-1:0] res, exp;
        int cyc;
        bit stable = 1'b1;
        send(4'b1000, 32'd12345, 32'd100, 32'd45);
        wait_out(res, cyc);
        exp = exp_q.pop_front();
        n_total++;
        if (out_valid !== 1'b1 || res !== exp)
            $display("FAIL hold_result: valid=%b result=%h required %h", out_valid, res, exp);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (result !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        n_total++;
        if (!stable)
            $display("FAIL hold_stable: result=%h valid=%b in_ready=%b required %h 1 0",
                     result, out_valid, in_ready, exp);
        else n_pass++;
        ack();
    endtask

    task automatic test_back_to_back();
        logic [3:0] op_tab[7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0110, 4'b1111};
        logic [3:0]   op;
        logic [W-1:0] a, b, res, exp;
        int cyc;
        for (int i = 0; i < 14; i++) begin
            op = op_tab[$urandom_range(0, 6)];
            a  = (i % 3 == 0) ? W'($urandom_range(0, 1000)) : $urandom;
            b  = (i % 4 == 0) ? W'($urandom_range(0, 20)) - 32'd10 : $urandom >> $urandom_range(0, 31);
            n_total++;
            if (in_ready !== 1'b1)
                $display("FAIL b2b_ready%0d: in_ready=%b required 1", i, in_ready);
            else n_pass++;
            send(op, a, b, model(op, a, b));
            wait_out(res, cyc);
            exp = exp_q.pop_front();
            n_total++;
            if (out_valid !== 1'b1 || res !== exp)
                $display("FAIL b2b%0d op=%b a=%h b=%h: result=%h required %h",
                         i, op, a, b, res, exp);
            else n_pass++;
            ack();
        end
    endtask

    task automatic test_async_reset();
        send(4'b0001, 32'd77, 32'd7, 32'd11);
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || result !== '0)
            $display("FAIL async_reset: in_ready=%b busy=%b out_valid=%b result=%h required 1 0 0 0",
                     in_ready, busy, out_valid, result);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_signed_edges();
        test_flush();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Multi-cycle controller for the EX-stage divider, issued by decode through its div flag with alu_op[3:0] reused as div_op.
- Accepts one divide/modulo request from EX.
- Runs a 32-iteration restoring radix-2 sequence on unsigned magnitudes, then applies sign correction.
- Holds the result until EX consumes it.
- An exception/ertn flush from WB cancels any operation in flight.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W

Ports:
clk  input  1  core clock, rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  EX presents a div/mod request (div flag & EX valid)
in_ready  output  1  controller can accept a request
div_op  input  4  one-hot: [0] div.w, [1] div.wu, [2] mod.w, [3] mod.wu
src1  input  DATA_W  dividend (rj)
src2  input  DATA_W  divisor (rk)
flush  input  1  WB exception/ertn flush (wb_ex)
out_valid  output  1  result ready
out_ready  input  1  EX consumes result this cycle
result  output  DATA_W  quotient or remainder selected by latched op
busy  output  1  state != IDLE; EX stalls its ready_go while busy or out_valid & ~out_ready

Behaviour:
- States: IDLE, CALC, DONE. Reset, asynchronous on resetn low:
  - state=IDLE, cnt=0, out_valid=0, result=0.
  - Internal op, sign and remainder registers are cleared.
- Outputs: in_ready = (state==IDLE). busy = (state!=IDLE). out_valid = (state==DONE).
- Accept happens on in_valid & in_ready & ~flush. On accept, latch:
  - the op;
  - signed flag = div_op[0]|div_op[2];
  - quotient sign = src1[31]^src2[31] (signed ops only);
  - remainder sign = src1[31] (signed ops only);
  - |src1| and |src2|.
  - Then cnt=DATA_W-1, partial remainder=0, and go to CALC.
- CALC performs one restoring step per cycle via div_step: shift in the next dividend MSB, then trial-subtract the divisor.
  - If the difference is non-negative, the quotient bit is 1 and the remainder is updated; otherwise the quotient bit is 0.
  - cnt decrements each cycle. The step taken with cnt==0 is the last; the next state is DONE.
- Latency: accept in cycle T, out_valid first high in cycle T+33 (32 CALC cycles plus 1 registered sign-fix into DONE).
- Sign fix:
  - Quotient is negated if the quotient sign is set.
  - Remainder is negated if the remainder sign is set.
  - Signed ops truncate toward zero, and the remainder takes the dividend's sign.
- result = quotient for div_op[0]|div_op[1], remainder for div_op[2]|div_op[3]. It is held stable throughout DONE.
- DONE: stay until out_ready, then go to IDLE. A new accept is possible in the following cycle; there is no same-cycle bypass.
- Divisor == 0 falls out of the algorithm naturally; no special path:
  - unsigned: q=32'hFFFF_FFFF, r=src1;
  - signed: q=~0 negated per quotient sign, r=src1.
- Overflow 0x8000_0000 / 0xFFFF_FFFF (signed): q=0x8000_0000, r=0. This falls out naturally; no special path.
- Flush has priority over everything:
  - It forces state to IDLE at the next edge from any state.
  - out_valid drops and no result is delivered.
  - A request presented in the same cycle is not accepted.
- in_valid is ignored while not IDLE. Operands and div_op are sampled only at accept, so EX may change them freely afterwards.
- div_op is not one-hot when in_valid is high: the request is accepted as mod.wu (lowest priority decode) and no error is signalled.

Decomposition:
- Shared macro header: DIV_OP_DIV_W/DIV_WU/MOD_W/MOD_WU bit indices (0..3), state encodings, DIV_LATENCY=33.
- Sub-module div_step: combinational single restoring iteration. Inputs: partial remainder, next dividend bit, divisor. Outputs: new remainder, quotient bit.

Test Plan:
1. div.wu src1=100, src2=7 accepted at T -> in_ready=0 from T+1; out_valid at T+33, result=14; out_ready=1 at T+33 -> IDLE at T+34.
2. mod.w src1=0xFFFF_FFF9 (-7), src2=2 -> result=0xFFFF_FFFF (-1). div.w on the same operands -> result=0xFFFF_FFFD (-3).
3. div.w src1=0x8000_0000, src2=0xFFFF_FFFF -> result=0x8000_0000. mod.w on the same operands -> result=0.
4. div.wu src2=0, src1=5 -> result=0xFFFF_FFFF. mod.wu on the same operands -> result=5.
5. Flush at T+10 of an operation -> state IDLE at T+11, no out_valid ever. A request with in_valid=1 and flush=1 in the same cycle -> not accepted, in_ready stays 1.
6. Result held with out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0. Assert resetn=0 mid-CALC -> all outputs reset immediately, without waiting for a clock edge.
